// File: rtl/bomb_pkg.sv
// Shared constants, slot phase encoding and blast-zone geometry helpers
// for the two-player bomb pool.
package bomb_pkg;

  localparam int DEF_FUSE_FRAMES  = 120;
  localparam int DEF_BLAST_FRAMES = 30;
  localparam int DEF_BOMB_SIZE    = 8;
  localparam int DEF_BLAST_RADIUS = 24;
  localparam int CNT_W            = 8;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FUSE  = 2'd1,
    S_BLAST = 2'd2
  } slot_state_t;

  // Larger-minus-smaller on zero-extended operands, so the result never wraps.
  function automatic logic [10:0] abs_diff11(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] ea;
    logic [10:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    if (ea >= eb) begin
      abs_diff11 = ea - eb;
    end else begin
      abs_diff11 = eb - ea;
    end
  endfunction

  function automatic logic in_zone(input logic [9:0] px, input logic [9:0] py,
                                   input logic [9:0] bx, input logic [9:0] by,
                                   input logic [10:0] radius);
    in_zone = (abs_diff11(px, bx) <= radius) && (abs_diff11(py, by) <= radius);
  endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: IDLE -> FUSE -> BLAST -> IDLE with a shared down-counter,
// plus the position and owner latched when the slot is started.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int FUSE_FRAMES  = DEF_FUSE_FRAMES,
  parameter int BLAST_FRAMES = DEF_BLAST_FRAMES
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [9:0] startX,
  input  logic [9:0] startY,
  input  logic       start_owner,
  output logic       busy,
  output logic       blast,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       owner
);

  slot_state_t      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [9:0]       x_r;
  logic [9:0]       y_r;
  logic             owner_r;

  // Phase sequencing; position and owner only change on a start from IDLE.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_r <= S_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      x_r     <= 10'd0;
      y_r     <= 10'd0;
      owner_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r <= S_FUSE;
            cnt_r   <= CNT_W'(FUSE_FRAMES - 1);
            x_r     <= startX;
            y_r     <= startY;
            owner_r <= start_owner;
          end
        end
        S_FUSE: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= S_BLAST;
            cnt_r   <= CNT_W'(BLAST_FRAMES - 1);
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        S_BLAST: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= S_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign busy  = (state_r != S_IDLE);
  assign blast = (state_r == S_BLAST);
  assign X     = x_r;
  assign Y     = y_r;
  assign owner = owner_r;

endmodule

// File: rtl/bomb_scheduler.sv
// Two-player bomb pool: drop-request edge detection, one-bomb-per-player
// limit, round-robin grant onto two slots, and registered blast-hit flags.
module bomb_scheduler
  import bomb_pkg::*;
#(
  parameter int FUSE_FRAMES  = DEF_FUSE_FRAMES,
  parameter int BLAST_FRAMES = DEF_BLAST_FRAMES,
  parameter int BOMB_SIZE    = DEF_BOMB_SIZE,
  parameter int BLAST_RADIUS = DEF_BLAST_RADIUS
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [1:0] drop_req,
  input  logic [9:0] p1X,
  input  logic [9:0] p1Y,
  input  logic [9:0] p2X,
  input  logic [9:0] p2Y,
  output logic [1:0] grant,
  output logic [1:0] slot_busy,
  output logic [1:0] slot_blast,
  output logic [1:0] slot_owner,
  output logic [9:0] bomb0X,
  output logic [9:0] bomb0Y,
  output logic [9:0] bomb1X,
  output logic [9:0] bomb1Y,
  output logic [9:0] bombS,
  output logic [1:0] hit
);

  logic [1:0] req_prev_r;
  logic [1:0] pending_r;
  logic       rr_ptr_r;
  logic [1:0] grant_r;
  logic [1:0] hit_r;

  logic [1:0] rise_s;
  logic [1:0] owns_s;
  logic [1:0] grant_s;
  logic [1:0] start_s;
  logic       rr_next_s;
  logic [1:0] pending_next_s;
  logic [1:0] hit_s;
  logic [9:0] win_x_s;
  logic [9:0] win_y_s;
  logic       win_owner_s;

  logic [1:0] busy_s;
  logic [1:0] blast_s;
  logic [1:0] owner_s;
  logic [9:0] bx_s [2];
  logic [9:0] by_s [2];

  assign rise_s = drop_req & ~req_prev_r;

  assign owns_s[0] = (busy_s[0] && (owner_s[0] == P1)) || (busy_s[1] && (owner_s[1] == P1));
  assign owns_s[1] = (busy_s[0] && (owner_s[0] == P2)) || (busy_s[1] && (owner_s[1] == P2));

  // Pick at most one winner and route it to the lowest free slot.
  always_comb begin
    grant_s   = 2'b00;
    start_s   = 2'b00;
    rr_next_s = rr_ptr_r;
    if (busy_s != 2'b11) begin
      if (pending_r == 2'b11) begin
        grant_s   = rr_ptr_r ? 2'b10 : 2'b01;
        rr_next_s = ~rr_ptr_r;
      end else begin
        grant_s = pending_r;
      end
    end else begin
      grant_s = 2'b00;
    end
    if (grant_s != 2'b00) begin
      start_s = busy_s[0] ? 2'b10 : 2'b01;
    end else begin
      start_s = 2'b00;
    end
  end

  assign win_owner_s = grant_s[1];
  assign win_x_s     = grant_s[1] ? p2X : p1X;
  assign win_y_s     = grant_s[1] ? p2Y : p1Y;

  // A fresh press is dropped if that player already has a bomb or is being granted now.
  assign pending_next_s = (pending_r & ~grant_s) | (rise_s & ~owns_s & ~grant_s);

  assign hit_s[0] = (blast_s[0] && in_zone(p1X, p1Y, bx_s[0], by_s[0], 11'(BLAST_RADIUS))) ||
                    (blast_s[1] && in_zone(p1X, p1Y, bx_s[1], by_s[1], 11'(BLAST_RADIUS)));
  assign hit_s[1] = (blast_s[0] && in_zone(p2X, p2Y, bx_s[0], by_s[0], 11'(BLAST_RADIUS))) ||
                    (blast_s[1] && in_zone(p2X, p2Y, bx_s[1], by_s[1], 11'(BLAST_RADIUS)));

  // Request bookkeeping, arbitration pointer and registered pulses/flags.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      req_prev_r <= 2'b00;
      pending_r  <= 2'b00;
      rr_ptr_r   <= 1'b0;
      grant_r    <= 2'b00;
      hit_r      <= 2'b00;
    end else begin
      req_prev_r <= drop_req;
      pending_r  <= pending_next_s;
      rr_ptr_r   <= rr_next_s;
      grant_r    <= grant_s;
      hit_r      <= hit_s;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : gen_slot
    bomb_slot #(
      .FUSE_FRAMES (FUSE_FRAMES),
      .BLAST_FRAMES(BLAST_FRAMES)
    ) u_slot (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .start      (start_s[i]),
      .startX     (win_x_s),
      .startY     (win_y_s),
      .start_owner(win_owner_s),
      .busy       (busy_s[i]),
      .blast      (blast_s[i]),
      .X          (bx_s[i]),
      .Y          (by_s[i]),
      .owner      (owner_s[i])
    );
  end

  assign grant      = grant_r;
  assign slot_busy  = busy_s;
  assign slot_blast = blast_s;
  assign slot_owner = owner_s;
  assign bomb0X     = bx_s[0];
  assign bomb0Y     = by_s[0];
  assign bomb1X     = bx_s[1];
  assign bomb1Y     = by_s[1];
  assign bombS      = 10'(BOMB_SIZE);
  assign hit        = hit_r;

endmodule

// File: doc/bomb_scheduler.md
# bomb_scheduler

Shared bomb-pool controller for two-player Bomberman. Arbitrates bomb-drop requests from both player controllers onto a pool of two bomb slots, sequences each slot through fuse and blast phases on frame_clk, and publishes bomb positions plus per-player blast-hit flags. These outputs feed the player blocks' bomb-collision inputs and the renderer.

## Interface
- FUSE_FRAMES, 120: frames a bomb sits armed before exploding.
- BLAST_FRAMES, 30: frames the blast stays active.
- BOMB_SIZE, 8: bomb edge length in pixels, driven on bombS.
- BLAST_RADIUS, 24: half-width of the square blast zone, in pixels.
- frame_clk  in  1  frame-rate clock; all state advances on its rising edge.
- Reset  in  1  reset Reset, asynchronous, active-high; clock frame_clk.
- drop_req  in  2  level drop requests from the keycode decode; bit0 is P1, bit1 is P2.
- p1X, p1Y, p2X, p2Y  in  10 each  current player positions.
- grant  out  2  one-frame pulse; the requester's bomb was placed.
- slot_busy  out  2  slot in FUSE or BLAST.
- slot_blast  out  2  slot in BLAST.
- slot_owner  out  2  owning player of each slot; 0 = P1, 1 = P2.
- bomb0X, bomb0Y, bomb1X, bomb1Y  out  10 each  latched slot positions.
- bombS  out  10  constant BOMB_SIZE.
- hit  out  2  per player, registered level; the player is inside any active blast.

## Operation
- **Request capture.** drop_req is registered into req_prev each edge. A rising bit (drop_req & ~req_prev) sets pending[p].
- **Discarding requests.** A rising edge is discarded if player p already owns a busy slot. Limit is one live bomb per player.
- **Arbitration.**
  - At most one grant per edge. A grant needs a pending requester and a free slot.
  - Slot choice: the lowest-index free slot.
  - If both players are pending, rr_ptr picks the winner (0 = P1 first).
  - rr_ptr toggles after every contested grant. The loser stays pending.
  - A granted request clears its pending bit.
- **Grant effects.** The slot latches the owner's X/Y and owner id, enters FUSE, and loads its counter with FUSE_FRAMES-1.
- **Slot FSM.**
  - IDLE → FUSE on grant.
  - FUSE: counter decrements each edge. At 0, go to BLAST and load BLAST_FRAMES-1.
  - BLAST: counter decrements each edge. At 0, go to IDLE.
  - bombX/Y hold their value in all states.
- **Hit detection.**
  - For each player and each slot in BLAST: |pX−bombX| ≤ BLAST_RADIUS and |pY−bombY| ≤ BLAST_RADIUS.
  - Differences use 11-bit unsigned arithmetic, computed as larger minus smaller. No wrap.
  - hit[p] is the OR over both slots, registered.
- **Owner exposure.** Hits apply to both players regardless of slot owner (friendly fire).

## Timing
- **Reset values.** All slots IDLE, counters 0, pending=0, req_prev=0, rr_ptr=0. grant, slot_busy, slot_blast, slot_owner, hit and bomb coordinates are all 0.
- **Reset mid-operation.** Active bombs vanish immediately and no pulses are emitted.
- **Grant latency.** An edge sampled at clock k sets pending at k. Grant and FUSE entry occur at k+1, so the grant pulse is high for exactly the one frame after k+1.
- **Phase durations.** slot_busy is high for exactly FUSE_FRAMES+BLAST_FRAMES frames. slot_blast is high for exactly BLAST_FRAMES frames.
- **Slot reuse.** A slot returning to IDLE at edge t can be granted at t+1, not at t.
- **Pool full.** With both slots busy, pending requests wait and are granted on the first edge with a free slot.
- **Held key.** A held drop_req produces no repeat; a new rising edge is required.
- **Hit latency.** hit lags slot_blast and position by one frame.

## Structure
- **Package bomb_pkg.**
  - slot_state_t enum {S_IDLE, S_FUSE, S_BLAST}.
  - Default FUSE_FRAMES / BLAST_FRAMES / BOMB_SIZE / BLAST_RADIUS constants.
  - Player-id constants P1=0, P2=1.
- **Sub-module bomb_slot, instantiated twice.**
  - Inputs: start, startX, startY, start_owner.
  - Contents: per-slot FSM, down-counter and latched position/owner.
  - Outputs: busy, blast, X, Y, owner.
- **Top level.** Edge detect, pending bits, round-robin arbiter and hit comparators.

## Test plan
- **Single drop.**
  - Stimulus: P1 at (100,100) raises drop_req[0] for one frame.
  - Required response:
    - grant[0] is pulsed one frame later.
    - slot0 is busy with bomb0=(100,100) and owner 0.
    - slot_blast goes high after 120 frames and stays high for 30.
    - slot0 returns to idle afterwards.
- **Simultaneous requests.**
  - Stimulus: both players rise on the same frame.
  - Required response:
    - P1 is granted slot0 first.
    - P2 is granted slot1 on the next frame.
    - Repeating after both slots clear gives P2 first (rr_ptr toggled).
- **Per-player limit.**
  - Stimulus: P1 drops, then raises drop_req[0] again 10 frames later.
  - Required response: no second grant, and pending[0] stays 0.
- **Blast hit.**
  - Stimulus: bomb at (200,200), P2 at (220,180) during BLAST; then P2 moved to (225,200).
  - Required response: hit[1]=1 one frame after blast start (both |Δ|=20 ≤ 24); hit[1]=0 after the move (|ΔX|=25).
- **Reset mid-fuse.**
  - Stimulus: assert Reset 50 frames into a fuse.
  - Required response:
    - All outputs go to 0 immediately, with no hit.
    - A new drop after reset is granted into slot0.
